// File: rtl/present_byte_seq.sv
// present_byte_seq: byte-stream wrapper around the PRESENT-80 core.
// Gathers key and plaintext bytes, starts the core once per block, waits
// for done under a timeout, and streams the ciphertext back out byte-wise.
module present_byte_seq #(
    parameter int KEY_BYTES = 10,
    parameter int PT_BYTES  = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   reuse_key,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   err_clr,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   core_done,
    output logic [KEY_BYTES*8-1:0] core_key,
    output logic [PT_BYTES*8-1:0]  core_pt,
    input  logic [PT_BYTES*8-1:0]  core_ct,
    output logic                   blk_done,
    output logic                   err
);

    localparam int MAX_BYTES = (KEY_BYTES > PT_BYTES) ? KEY_BYTES : PT_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_BYTES - 1);
    localparam logic [IDX_W-1:0] PT_LAST  = IDX_W'(PT_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_KEY,
        S_PT,
        S_START,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [KEY_BYTES*8-1:0] coreKey_q, coreKey_d;
    logic [PT_BYTES*8-1:0]  corePt_q, corePt_d;
    logic [PT_BYTES*8-1:0]  ctReg_q, ctReg_d;
    logic                   coreStart_q, coreStart_d;
    logic                   blkDone_q, blkDone_d;
    logic                   err_q, err_d;
    logic [7:0]             outByte;

    // core_busy is status only; sequencing relies solely on core_done.
    logic unusedBusy;
    assign unusedBusy = core_busy;

    // Handshake signals decode the state register only, so no
    // combinational path exists from in_valid or out_ready.
    assign in_ready   = (state_q == S_KEY) || (state_q == S_PT);
    assign out_valid  = (state_q == S_OUT);
    assign out_data   = outByte;
    assign core_start = coreStart_q;
    assign core_key   = coreKey_q;
    assign core_pt    = corePt_q;
    assign blk_done   = blkDone_q;
    assign err        = err_q;

    // Select the current ciphertext byte, most significant byte first.
    always_comb begin
        outByte = '0;
        for (int b = 0; b < PT_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                outByte = ctReg_q[(PT_BYTES-1-b)*8 +: 8];
            end
        end
    end

    // Next-state logic: byte loading, start pulse, timed wait, byte output.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        coreKey_d   = coreKey_q;
        corePt_d    = corePt_q;
        ctReg_d     = ctReg_q;
        coreStart_d = 1'b0;
        blkDone_d   = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_KEY: begin
                if (in_valid) begin
                    for (int b = 0; b < KEY_BYTES; b++) begin
                        if (idx_q == IDX_W'(b)) begin
                            coreKey_d[(KEY_BYTES-1-b)*8 +: 8] = in_data;
                        end
                    end
                    if (idx_q == KEY_LAST) begin
                        idx_d   = '0;
                        state_d = S_PT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PT: begin
                if (in_valid) begin
                    for (int b = 0; b < PT_BYTES; b++) begin
                        if (idx_q == IDX_W'(b)) begin
                            corePt_d[(PT_BYTES-1-b)*8 +: 8] = in_data;
                        end
                    end
                    if (idx_q == PT_LAST) begin
                        idx_d       = '0;
                        state_d     = S_START;
                        coreStart_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (core_done) begin
                    ctReg_d = core_ct;
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TMR_LAST) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == PT_LAST) begin
                        idx_d     = '0;
                        blkDone_d = 1'b1;
                        state_d   = reuse_key ? S_PT : S_KEY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_KEY;
                end
            end
            default: begin
                state_d = S_KEY;
                idx_d   = '0;
            end
        endcase
    end

    // State and datapath registers, all cleared by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_KEY;
            idx_q       <= '0;
            timer_q     <= '0;
            coreKey_q   <= '0;
            corePt_q    <= '0;
            ctReg_q     <= '0;
            coreStart_q <= 1'b0;
            blkDone_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            coreKey_q   <= coreKey_d;
            corePt_q    <= corePt_d;
            ctReg_q     <= ctReg_d;
            coreStart_q <= coreStart_d;
            blkDone_q   <= blkDone_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_present_byte_seq.sv
// tb_present_byte_seq: directed bench for present_byte_seq with a core stub
// that answers from a table of known PRESENT-80 test vectors.
module tb_present_byte_seq;

    localparam int KEY_BYTES = 10;
    localparam int PT_BYTES  = 8;
    localparam int TIMEOUT   = 64;

    logic                   clk;
    logic                   reset;
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   reuse_key;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   err_clr;
    logic                   core_start;
    logic                   core_busy;
    logic                   core_done;
    logic [KEY_BYTES*8-1:0] core_key;
    logic [PT_BYTES*8-1:0]  core_pt;
    logic [PT_BYTES*8-1:0]  core_ct;
    logic                   blk_done;
    logic                   err;

    int checkCount   = 0;
    int errorCount   = 0;
    int startCount   = 0;
    int blkCount     = 0;
    int inReadyViol  = 0;
    bit inFlight     = 0;

    int stubDelay    = 5;
    bit stubNever    = 0;
    int stubCnt;
    bit stubArmed;

    present_byte_seq #(
        .KEY_BYTES(KEY_BYTES),
        .PT_BYTES (PT_BYTES),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reuse_key (reuse_key),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .core_start(core_start),
        .core_busy (core_busy),
        .core_done (core_done),
        .core_key  (core_key),
        .core_pt   (core_pt),
        .core_ct   (core_ct),
        .blk_done  (blk_done),
        .err       (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known-answer table for the core stub; unknown inputs give a marker.
    function automatic logic [63:0] ctLookup(input logic [79:0] k, input logic [63:0] p);
        if (k == '0 && p == '0) return 64'h5579C1387B228445;
        if (k == '1 && p == '0) return 64'hE72C46C0F5945049;
        if (k == '1 && p == '1) return 64'h3333DCD3213210D2;
        if (k == '0 && p == '1) return 64'hA112FFC72F68417B;
        return 64'hBAD0BAD0BAD0BAD0;
    endfunction

    // Core stub: latches the answer on start and pulses done a fixed number
    // of cycles later, or never when stubNever is set.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stubArmed <= 1'b0;
            stubCnt   <= 0;
            core_done <= 1'b0;
            core_ct   <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start) begin
                stubArmed <= 1'b1;
                stubCnt   <= 0;
                core_ct   <= ctLookup(core_key, core_pt);
            end else if (stubArmed) begin
                if (stubCnt == stubDelay) begin
                    core_done <= !stubNever;
                    stubArmed <= 1'b0;
                end
                stubCnt <= stubCnt + 1;
            end
        end
    end
    assign core_busy = stubArmed;

    // Monitor: counts start and blk_done pulses and flags in_ready while a
    // block is between start and completion.
    always @(negedge clk) begin
        if (!reset || blk_done || err) inFlight = 1'b0;
        else if (core_start) inFlight = 1'b1;
        if (core_start) startCount++;
        if (blk_done) blkCount++;
        if (inFlight && in_ready) inReadyViol++;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one input byte and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [7:0] b, input bit jitter);
        int guard = 0;
        if (jitter && ($urandom_range(1, 0) == 1)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_wait", 80'(in_ready), 80'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send n copies of a byte value.
    task automatic loadBytes(input int n, input logic [7:0] b, input bit jitter);
        for (int i = 0; i < n; i++) applyStimulus(b, jitter);
    endtask

    // Load (optionally) a key and a plaintext, then collect and check all
    // ciphertext bytes, the blk_done pulse and the pulse counts.
    task automatic runBlock(input string tag, input bit loadKey, input logic [7:0] keyByte,
                            input logic [7:0] ptByte, input bit jitter, input bit stall,
                            input bit reuse, input logic [63:0] expCt);
        int sB = startCount;
        int bB = blkCount;
        int vB = inReadyViol;
        int guard;
        int drift;
        logic [7:0] held;
        reuse_key = reuse;
        out_ready = 1'b1;
        if (loadKey) loadBytes(KEY_BYTES, keyByte, jitter);
        loadBytes(PT_BYTES, ptByte, jitter);
        guard = 0;
        while (!out_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) begin
            checkOutput({tag, "_out_valid_wait"}, 80'(out_valid), 80'(1));
            return;
        end
        for (int i = 0; i < PT_BYTES; i++) begin
            if (stall && i == 3) begin
                out_ready = 1'b0;
                held  = out_data;
                drift = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (out_data !== held || out_valid !== 1'b1) drift++;
                end
                checkOutput({tag, "_stall_stable"}, 80'(drift), 80'(0));
                out_ready = 1'b1;
            end
            checkOutput($sformatf("%s_byte%0d", tag, i), 80'(out_data), 80'(expCt[63-8*i -: 8]));
            @(negedge clk);
        end
        checkOutput({tag, "_blk_done"}, 80'(blk_done), 80'(1));
        checkOutput({tag, "_out_valid_end"}, 80'(out_valid), 80'(0));
        checkOutput({tag, "_in_ready_end"}, 80'(in_ready), 80'(1));
        @(negedge clk);
        #1;
        checkOutput({tag, "_start_pulses"}, 80'(startCount - sB), 80'(1));
        checkOutput({tag, "_blk_pulses"}, 80'(blkCount - bB), 80'(1));
        checkOutput({tag, "_in_ready_busy"}, 80'(inReadyViol - vB), 80'(0));
        reuse_key = 1'b0;
    endtask

    // Check all outputs against their reset values.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 80'(in_ready), 80'(1));
        checkOutput({tag, "_out_valid"}, 80'(out_valid), 80'(0));
        checkOutput({tag, "_out_data"}, 80'(out_data), 80'(0));
        checkOutput({tag, "_core_start"}, 80'(core_start), 80'(0));
        checkOutput({tag, "_blk_done"}, 80'(blk_done), 80'(0));
        checkOutput({tag, "_err"}, 80'(err), 80'(0));
        checkOutput({tag, "_core_key"}, core_key, 80'(0));
        checkOutput({tag, "_core_pt"}, 80'(core_pt), 80'(0));
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checkCount, errorCount);
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int guard;
        reset     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        reuse_key = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("reset");

        // All-zero key and plaintext.
        runBlock("t1", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 64'h5579C1387B228445);

        // All-ones key, then reuse it for an all-ones plaintext.
        runBlock("t2a", 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 64'hE72C46C0F5945049);
        runBlock("t2b", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h3333DCD3213210D2);
        checkOutput("t2_key_kept", core_key, '1);

        // Jittered input valid and an output stall.
        runBlock("t3", 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 64'hA112FFC72F68417B);

        // Core never answers: timeout, error, then recovery.
        stubNever = 1'b1;
        loadBytes(KEY_BYTES, 8'h00, 1'b0);
        loadBytes(PT_BYTES, 8'h00, 1'b0);
        guard = 0;
        while (!core_start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("t4_start_seen", 80'(core_start), 80'(1));
        repeat (TIMEOUT) @(negedge clk);
        checkOutput("t4_err_before", 80'(err), 80'(0));
        @(negedge clk);
        checkOutput("t4_err_rise", 80'(err), 80'(1));
        checkOutput("t4_err_in_ready", 80'(in_ready), 80'(0));
        checkOutput("t4_err_out_valid", 80'(out_valid), 80'(0));
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("t4_err_held", 80'(err), 80'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("t4_err_clr", 80'(err), 80'(0));
        checkOutput("t4_clr_in_ready", 80'(in_ready), 80'(1));
        stubNever = 1'b0;
        runBlock("t4_after", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h3333DCD3213210D2);

        // Reset during a partial key load.
        loadBytes(4, 8'hFF, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("t5_midreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        runBlock("t5_after", 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 64'hE72C46C0F5945049);

        // Done arrives on the final timer cycle: capture wins over timeout.
        stubDelay = TIMEOUT - 2;
        runBlock("t6", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 64'h5579C1387B228445);
        checkOutput("t6_err", 80'(err), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/present_byte_seq.md
Name: present_byte_seq

Overview:
- Byte-stream front/back end for the PRESENT-80 encryption core; sits between the Pico2 port interface and the core.
- Collects an 80-bit key and a 64-bit plaintext as bytes over a valid/ready input stream and issues a one-cycle start to the core.
- Waits for done, with a timeout, then captures the ciphertext and streams it out byte-wise over a valid/ready output stream.
- Removes per-byte idx/key/pt/ctrl port traffic from firmware.

Parameters:
- KEY_BYTES, 10, number of key bytes (core key width = KEY_BYTES*8).
- PT_BYTES, 8, plaintext/ciphertext bytes (block width = PT_BYTES*8).
- TIMEOUT, 64, maximum cycles spent in WAIT before flagging an error (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  key/plaintext byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- reuse_key  in  1  1 = skip key load for the next block; sampled on the last output byte.
- out_data  out  8  ciphertext byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- err_clr  in  1  clears the error state (pulse).
- core_start  out  1  one-cycle start pulse to the core.
- core_busy  in  1  core busy (status only, not used for sequencing).
- core_done  in  1  core done pulse.
- core_key  out  80  key to the core (KEY_BYTES*8).
- core_pt  out  64  plaintext to the core (PT_BYTES*8).
- core_ct  in  64  ciphertext from the core.
- blk_done  out  1  one-cycle pulse after the last ciphertext byte is transferred.
- err  out  1  timeout error flag; high while in ERR.

Behaviour:
- States: KEY, PT, START, WAIT, OUT, ERR. All registers are clocked on clk and cleared by reset.
- Reset values: state=KEY, idx=0, timer=0, core_key=0, core_pt=0, ct_reg=0, core_start=0, blk_done=0, err=0. Derived outputs at reset: in_ready=1, out_valid=0, out_data=0.
- in_ready = (state==KEY || state==PT). out_valid = (state==OUT). Both are pure decodes of the state register, with no combinational path from in_valid or out_ready.
- Byte ordering is big-endian: byte idx 0 maps to the most significant byte (core_key[79:72], core_pt[63:56], ct_reg[63:56]).
- KEY: on each in_valid&in_ready, write byte idx of core_key and increment idx. On the transfer with idx==KEY_BYTES-1: idx←0, state←PT.
- PT: same rule into core_pt. On the transfer with idx==PT_BYTES-1: idx←0, state←START.
- START: core_start=1 for exactly this cycle. Next cycle: state←WAIT, timer←0.
- START/done collision: core_done is ignored in START.
- WAIT: in_ready=0.
  - If core_done: ct_reg←core_ct, idx←0, state←OUT. This takes priority over the timeout in the same cycle.
  - Else: timer←timer+1. When timer==TIMEOUT-1 with no done: state←ERR, err←1.
- OUT: out_data = ct_reg byte idx. On out_valid&out_ready: idx increments.
  - On the transfer with idx==PT_BYTES-1: blk_done pulses the next cycle, idx←0.
  - Next state is PT if reuse_key==1 at that cycle, else KEY.
  - Holding out_ready low stalls indefinitely with data and idx stable.
- core_key and core_pt hold their values across blocks. With reuse_key, only core_pt is rewritten.
- in_valid is ignored outside KEY/PT; no byte is consumed.
- ERR: in_ready=0, out_valid=0, core_start=0. On err_clr: err←0, idx←0, state←KEY. err_clr is ignored in all other states.
- A late core_done arriving in ERR is ignored.
- reset asserted mid-operation: immediate return to reset values. A partially loaded key or plaintext is discarded and no output byte is emitted.
- core_start must never be asserted twice for one block.

Test Plan:
- Key 00×10, pt 00×8, out_ready=1 → exactly one core_start pulse; out bytes 55 79 C1 38 7B 22 84 45; one blk_done pulse; state returns to KEY.
- Key FF×10, pt 00×8 → out E7 2C 46 C0 F5 94 50 49. Then with reuse_key=1, send pt FF×8 only → out 33 33 DC D3 21 32 10 D2, with no key bytes consumed.
- Key 00×10, pt FF×8 with in_valid toggled randomly and out_ready low for 5 cycles mid-stream → out A1 12 FF C7 2F 68 41 7B; out_data stable while stalled; in_ready low throughout WAIT/OUT.
- Core stub never asserts done, TIMEOUT=64 → err rises exactly 64 cycles after entering WAIT; in_ready=0 in ERR. Pulse err_clr → err=0, in_ready=1; a new key loads normally.
- Assert reset after 4 key bytes → all outputs at reset values; a fresh full key+pt load produces the correct ciphertext.
- core_done asserted on the same cycle as timer==TIMEOUT-1 → ciphertext is captured, state goes to OUT, err stays 0.
